// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and default widths for the data-memory port arbiter and the DM itself.
package dm_port_arbiter_pkg;

    localparam int unsigned DM_ADDR_BITS = 12;
    localparam int unsigned DM_DATA_W    = 32;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        HOST_OWED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } rd_owner_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundles the CPU MEM-stage port, the host/loader port and the DM port of the arbiter.
interface dm_port_arbiter_if
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DM_ADDR_BITS,
    parameter int unsigned DATA_W    = DM_DATA_W
) ();

    logic                 cpu_req;
    logic                 cpu_we;
    logic [ADDR_BITS-1:0] cpu_addr;
    logic [DATA_W-1:0]    cpu_wdata;
    logic                 cpu_stall;
    logic [DATA_W-1:0]    cpu_rdata;
    logic                 cpu_rvalid;

    logic                 host_req;
    logic                 host_we;
    logic [ADDR_BITS-1:0] host_addr;
    logic [DATA_W-1:0]    host_wdata;
    logic                 host_gnt;
    logic [DATA_W-1:0]    host_rdata;
    logic                 host_rvalid;

    logic                 dm_en;
    logic                 dm_we;
    logic [ADDR_BITS-1:0] dm_addr;
    logic [DATA_W-1:0]    dm_wdata;
    logic [DATA_W-1:0]    dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output dm_en, dm_we, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  dm_en, dm_we, dm_addr, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/dm_arb_starve_ctr.sv
// Saturating count of consecutive denied host cycles; reached flags the limit.
module dm_arb_starve_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       reached,
    output logic [7:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < limit)) begin
            count <= count + 8'd1;
        end
    end

    always_comb begin
        reached = (count >= limit);
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the DM port between the CPU MEM stage (priority) and the host loader port.
// Define DM_ARB_PERF_EN to add the perf_cpu_stalls / perf_host_grants counters.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = DM_ADDR_BITS,
    parameter int unsigned DATA_W       = DM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               input_clk,
    input  logic               rst,
    dm_port_arbiter_if.slave   bus
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_cpu_stalls,
    output logic [31:0]        perf_host_grants
`endif
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_t           state;
    rd_owner_t            rd_owner_q;
    logic                 rd_pend_q;
    logic                 cpu_sel;
    logic                 host_sel;
    logic                 cpu_rv;
    logic                 host_rv;
    logic                 dm_we_c;
    logic [ADDR_BITS-1:0] dm_addr_c;
    logic [DATA_W-1:0]    dm_wdata_c;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    cpu_rdata_q;
    logic [DATA_W-1:0]    host_rdata_q;
    logic                 starve_inc;
    logic                 starve_clr;
    logic                 starve_reached;
    logic [7:0]           starve_cnt;
    logic                 owe_next;

    dm_arb_starve_ctr u_starve (
        .clk     (input_clk),
        .rst     (rst),
        .inc     (starve_inc),
        .clr     (starve_clr),
        .limit   (LIMIT),
        .reached (starve_reached),
        .count   (starve_cnt)
    );

    always_comb begin
        host_sel   = bus.host_req & ((state == HOST_OWED) | ~bus.cpu_req);
        cpu_sel    = bus.cpu_req & ~host_sel;
        starve_inc = bus.host_req & ~host_sel;
        starve_clr = host_sel | ~bus.host_req;
        // State mirrors the counter value that will be latched on this edge.
        owe_next   = starve_inc & (starve_reached | ((starve_cnt + 8'd1) == LIMIT));
    end

    always_comb begin
        dm_we_c    = 1'b0;
        dm_addr_c  = addr_q;
        dm_wdata_c = wdata_q;
        if (cpu_sel) begin
            dm_we_c    = bus.cpu_we;
            dm_addr_c  = bus.cpu_addr;
            dm_wdata_c = bus.cpu_wdata;
        end else if (host_sel) begin
            dm_we_c    = bus.host_we;
            dm_addr_c  = bus.host_addr;
            dm_wdata_c = bus.host_wdata;
        end
    end

    always_comb begin
        cpu_rv          = rd_pend_q & (rd_owner_q == OWN_CPU);
        host_rv         = rd_pend_q & (rd_owner_q == OWN_HOST);
        bus.cpu_stall   = bus.cpu_req & ~cpu_sel;
        bus.host_gnt    = host_sel;
        bus.dm_en       = cpu_sel | host_sel;
        bus.dm_we       = dm_we_c;
        bus.dm_addr     = dm_addr_c;
        bus.dm_wdata    = dm_wdata_c;
        bus.cpu_rvalid  = cpu_rv;
        bus.host_rvalid = host_rv;
        bus.cpu_rdata   = cpu_rv ? bus.dm_rdata : cpu_rdata_q;
        bus.host_rdata  = host_rv ? bus.dm_rdata : host_rdata_q;
    end

    always_ff @(posedge input_clk or posedge rst) begin
        if (rst) begin
            state        <= CPU_PRI;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWN_CPU;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state     <= owe_next ? HOST_OWED : CPU_PRI;
            rd_pend_q <= (cpu_sel & ~bus.cpu_we) | (host_sel & ~bus.host_we);
            if (cpu_sel | host_sel) begin
                rd_owner_q <= host_sel ? OWN_HOST : OWN_CPU;
                addr_q     <= dm_addr_c;
                wdata_q    <= dm_wdata_c;
            end
            if (cpu_rv) begin
                cpu_rdata_q <= bus.dm_rdata;
            end
            if (host_rv) begin
                host_rdata_q <= bus.dm_rdata;
            end
        end
    end

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge input_clk or posedge rst) begin
        if (rst) begin
            perf_cpu_stalls  <= '0;
            perf_host_grants <= '0;
        end else begin
            if (bus.cpu_req & ~cpu_sel) begin
                perf_cpu_stalls <= perf_cpu_stalls + 32'd1;
            end
            if (host_sel) begin
                perf_host_grants <= perf_host_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single port of the data memory (DM) between the pipelined CPU's MEM stage and a host/loader port used for program/data preload and result dump. The CPU has priority, and the MEM stage is stalled whenever it loses arbitration. A starvation counter guarantees the host a slot under sustained CPU traffic. The block sits between MEM_stage/PL_CPU and DM, and read data is steered back to whichever requester owns the in-flight read.

## Interface
- ADDR_BITS, 12, DM word-address width; matches MEMORY_BITS.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, number of consecutive denied host cycles after which the host wins the next contested cycle; legal range 1–255.

- input_clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cpu_req  in  1  MEM stage access request (MemRead|MemWrite).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_BITS  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request denied this cycle; pipeline must hold.
- cpu_rdata  out  DATA_W  read data for the CPU.
- cpu_rvalid  out  1  cpu_rdata valid.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_BITS/DATA_W  host request, same meaning as the CPU fields.
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  DATA_W  read data for the host.
- host_rvalid  out  1  host_rdata valid.
- dm_en, dm_we  out  1/1  DM port enable and write enable.
- dm_addr, dm_wdata  out  ADDR_BITS/DATA_W  DM port address and write data.
- dm_rdata  in  DATA_W  DM read data, registered inside DM (1-cycle latency).

## Operation
- Requests are level-held until served. Grant logic is combinational from the requests, starve_cnt and the state register.
- State HOST_OWED is entered when starve_cnt reaches STARVE_LIMIT; otherwise the state is CPU_PRI.
- CPU_PRI:
  - cpu_req is granted if asserted.
  - Otherwise host_req is granted if asserted.
- HOST_OWED:
  - If host_req is asserted, the host is granted even when cpu_req is asserted.
  - If host_req has dropped, return to CPU_PRI with no grant forced.
- Return to CPU_PRI after any host grant.
- cpu_stall = cpu_req & ~cpu_granted. host_gnt = host_req & host_granted.
- starve_cnt (8 bits):
  - Increments, saturating at STARVE_LIMIT, when host_req & ~host_gnt.
  - Clears on host_gnt or when host_req is low.
- dm_* are muxed from the granted requester. With no grant: dm_en=0, dm_we=0, and dm_addr/dm_wdata hold their last values.
- Read ownership: on a granted read, rd_owner_q ← requester and rd_pend_q ← 1.
  - On the next cycle dm_rdata is routed to the owner, and that owner's rvalid is 1 for one cycle.
  - The non-owner's rdata is held at its last value.
- Writes produce no rvalid.
- Back-to-back reads by alternating owners are legal. Each return follows its own grant by exactly one cycle.

## Timing
- Grant and stall take effect in the same cycle as the request; there is no added latency on the request path.
- Read latency is 1 cycle from grant to rvalid.
- Reset values: cpu_stall=0 (with cpu_req low), host_gnt=0, cpu_rvalid=0, host_rvalid=0, cpu_rdata=0, host_rdata=0, dm_en=0, dm_we=0, dm_addr=0, dm_wdata=0, starve_cnt=0, state=CPU_PRI.
- Reset asserted mid-read drops the pending return: no rvalid is issued after reset deasserts.
- Simultaneous requests in CPU_PRI: CPU wins, host_gnt=0, and starve_cnt increments.
- STARVE_LIMIT=1: the host wins every second contested cycle.

## Configuration
- DM_ARB_PERF_EN defined adds two 32-bit outputs, both reset to 0, wrapping at 2^32:
  - perf_cpu_stalls: increments each cycle cpu_stall=1.
  - perf_host_grants: increments each cycle host_gnt=1.
- DM_ARB_PERF_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package holds:
  - State encodings CPU_PRI=1'b0, HOST_OWED=1'b1.
  - Owner encoding OWN_CPU=1'b0, OWN_HOST=1'b1.
  - Default ADDR_BITS/DATA_W constants, shared with DM.
- One sub-module, dm_arb_starve_ctr: saturating counter with inputs inc, clr and limit, and output reached. The grant mux, state register and read-return steering stay in the top module.

## Test plan
- Reset; host writes 0xDEADBEEF to addr 0x010 with no CPU traffic -> host_gnt=1 the same cycle; dm_we=1, dm_addr=0x010.
- Host reads addr 0x010 -> host_rvalid=1 exactly 1 cycle later with host_rdata=0xDEADBEEF; cpu_rvalid stays 0.
- cpu_req and host_req both held high continuously, STARVE_LIMIT=8 -> CPU granted for 8 cycles; the 9th cycle is a host grant with cpu_stall=1; the pattern repeats.
- CPU read of 0x020 granted, then host read of 0x030 the next cycle -> cpu_rvalid then host_rvalid on consecutive cycles, each carrying its own data.
- rst pulsed in the cycle after a granted CPU read -> no cpu_rvalid afterwards; all outputs at reset values.
- With DM_ARB_PERF_EN, run the contention scenario for 18 cycles -> perf_cpu_stalls=2, perf_host_grants=2.
